newtag_bist_ctrl: RTL and testbench



---
 rtl/newtag_bist_pkg.sv | 36 +++
 rtl/newtag_misr.sv | 36 +++
 rtl/newtag_bist_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_newtag_bist_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/newtag_bist_pkg.sv
// Purpose: shared types, default constants and the MISR step function for the newtag BIST controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bist_state_e FSM encoding, DEF_SIG_POLY / DEF_SIG_SEED defaults, misr_next().
package newtag_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
    localparam logic [15:0] DEF_SIG_SEED = 16'h0000;

    // Widest signature the helper supports; callers zero-extend into this width.
    localparam int SIG_MAX_W = 32;

    // One MISR step: shift left, fold the polynomial back in when the bit
    // shifted out was set, and XOR the serial input into bit 0. Bits above
    // 'width' are masked so a narrow register can use the wide helper.
    function automatic logic [SIG_MAX_W-1:0] misr_next(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] poly,
        input logic                 din,
        input int                   width
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] nxt;
        mask = (width >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << width) - SIG_MAX_W'(1));
        nxt  = (sig << 1) ^ (sig[width-1] ? poly : '0) ^ {{(SIG_MAX_W-1){1'b0}}, din};
        return nxt & mask;
    endfunction

endpackage

// File: rtl/newtag_misr.sv
// Purpose: SIG_W-wide multiple-input signature register with seed load, enable and serial input.
// Latency: signature reflects din one clock after an enabled edge.
// Backpressure: none; en simply holds the value when low.
// Ports: clk, rst (sync, active-high), load (reload seed, wins over en), en, din, sig.
module newtag_misr
    import newtag_bist_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_MAX_W-1:0] sig_nxt;

    always_comb begin
        sig_nxt = misr_next(SIG_MAX_W'(sig), SIG_MAX_W'(SIG_POLY), din, SIG_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SIG_SEED;
        end else if (load) begin
            sig <= SIG_SEED;
        end else if (en) begin
            sig <= sig_nxt[SIG_W-1:0];
        end
    end

endmodule

// File: rtl/newtag_bist_ctrl.sv
// Purpose: exhaustive-stimulus BIST for an N_IN-input / 1-output netlist; sweeps pi_vec, compacts po_in.
// Latency: done rises 2^N_IN+LAT+1 clocks after the edge that accepts start.
// Backpressure: none; start while busy is dropped, the sweep runs at one vector per clock.
// Ports: clk/rst (sync, active-high); start, exp_ones, exp_sig (golden, captured on start);
//        pi_vec (stimulus), po_in (response); busy, done, ones_cnt, signature, pass.
// Optional: NEWTAG_BIST_FIRST_FAIL_EN adds exp_in, fail_seen, first_fail_vec.
module newtag_bist_ctrl
    import newtag_bist_pkg::*;
#(
    parameter int               N_IN     = 8,
    parameter int               LAT      = 0,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_IN:0]     exp_ones,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic [N_IN-1:0]   pi_vec,
    input  logic              po_in,
`ifdef NEWTAG_BIST_FIRST_FAIL_EN
    input  logic              exp_in,
    output logic              fail_seen,
    output logic [N_IN-1:0]   first_fail_vec,
`endif
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     ones_cnt,
    output logic [SIG_W-1:0]  signature,
    output logic              pass
);

    localparam logic [N_IN-1:0] VEC_LAST   = '1;
    localparam int              DRAIN_LAST = (LAT > 0) ? LAT - 1 : 0;

    bist_state_e        state_q;
    bist_state_e        state_d;
    logic               accept;
    logic               issue;
    logic               sample_en;
    logic [1:0]         drain_cnt;
    logic [N_IN:0]      exp_ones_q;
    logic [SIG_W-1:0]   exp_sig_q;

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (pi_vec == VEC_LAST) begin
                    state_d = (LAT > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST[1:0]) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);

    // ------------------------------------------------------------------
    // Stimulus, drain timer, golden capture, done flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pi_vec     <= '0;
            drain_cnt  <= '0;
            exp_ones_q <= '0;
            exp_sig_q  <= '0;
            done       <= 1'b0;
        end else begin
            if (accept) begin
                pi_vec <= '0;
            end else if (issue && (pi_vec != VEC_LAST)) begin
                // Stimulus parks at all-ones after the last vector until the next start.
                pi_vec <= pi_vec + 1'b1;
            end

            if (state_q == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end else begin
                drain_cnt <= '0;
            end

            if (accept) begin
                exp_ones_q <= exp_ones;
                exp_sig_q  <= exp_sig;
            end

            // done lags entry to DONE by a clock so the final sample has
            // settled into the counters before it is reported.
            if (accept) begin
                done <= 1'b0;
            end else if (state_q == DONE) begin
                done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue tag pipeline: aligns sampling with the DUT's register depth
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_no_lat
            assign sample_en = issue;
        end else begin : g_lat
            logic [LAT-1:0] vld_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= issue;
                    for (int i = 1; i < LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end
            assign sample_en = vld_sr[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response compaction
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (accept) begin
            ones_cnt <= '0;
        end else if (sample_en) begin
            ones_cnt <= ones_cnt + {{N_IN{1'b0}}, po_in};
        end
    end

    newtag_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .SIG_SEED (SIG_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (sample_en),
        .din  (po_in),
        .sig  (signature)
    );

`ifdef NEWTAG_BIST_FIRST_FAIL_EN
    // Sample index rather than a delayed pi_vec: samples arrive in vector
    // order, so a counter names the failing vector for any LAT.
    logic [N_IN-1:0] samp_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_idx       <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
        end else if (accept) begin
            samp_idx       <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
        end else if (sample_en) begin
            samp_idx <= samp_idx + 1'b1;
            if (!fail_seen && (po_in != exp_in)) begin
                fail_seen      <= 1'b1;
                first_fail_vec <= samp_idx;
            end
        end
    end

    always_comb begin
        pass = done && (ones_cnt == exp_ones_q) && (signature == exp_sig_q) && !fail_seen;
    end
`else
    always_comb begin
        pass = done && (ones_cnt == exp_ones_q) && (signature == exp_sig_q);
    end
`endif

endmodule

// File: tb/tb_newtag_bist_ctrl.sv
`timescale 1ns/1ps
module tb_newtag_bist_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start2;
    logic [8:0]  exp_ones0, exp_ones2;
    logic [15:0] exp_sig0, exp_sig2;
    logic [7:0]  pi0, pi2;
    logic        po0, po2;
    logic        busy0, busy2, done0, done2, pass0, pass2;
    logic [8:0]  ones0, ones2;
    logic [15:0] sig0, sig2;
`ifdef NEWTAG_BIST_FIRST_FAIL_EN
    logic        fail0, fail2;
    logic [7:0]  ffv0, ffv2;
`endif

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    // Mock benchmark for the LAT=0 controller: purely combinational.
    function automatic logic po_model(input int m, input logic [7:0] v);
        case (m)
            1:       return &v;
            2:       return v[0];
            3:       return 1'b1;
            4:       return (v == 8'h5A);
            default: return 1'b0;
        endcase
    endfunction

    always_comb po0 = po_model(mode, pi0);

    // Mock benchmark for the LAT=2 controller: pi[0] through two registers.
    logic r1, r2;
    always_ff @(posedge clk) begin
        r1 <= pi2[0];
        r2 <= r1;
    end
    assign po2 = r2;

    newtag_bist_ctrl #(.N_IN(8), .LAT(0), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .exp_ones(exp_ones0), .exp_sig(exp_sig0),
        .pi_vec(pi0), .po_in(po0),
`ifdef NEWTAG_BIST_FIRST_FAIL_EN
        .exp_in(1'b0), .fail_seen(fail0), .first_fail_vec(ffv0),
`endif
        .busy(busy0), .done(done0), .ones_cnt(ones0), .signature(sig0), .pass(pass0)
    );

    newtag_bist_ctrl #(.N_IN(8), .LAT(2), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'h0000)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .exp_ones(exp_ones2), .exp_sig(exp_sig2),
        .pi_vec(pi2), .po_in(po2),
`ifdef NEWTAG_BIST_FIRST_FAIL_EN
        .exp_in(po2), .fail_seen(fail2), .first_fail_vec(ffv2),
`endif
        .busy(busy2), .done(done2), .ones_cnt(ones2), .signature(sig2), .pass(pass2)
    );

    typedef struct {
        string       tag;
        logic [8:0]  ones;
        logic [15:0] sig;
        logic        pass;
        int          lat;
    } exp_t;

    exp_t sb[$];

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'h0000, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Golden model of a whole sweep; ff_live means exp_in is tied 0 so any
    // po=1 counts as a mismatch when the first-fail feature is built in.
    task automatic push_model(input string tag, input int m, input logic [8:0] eo,
                              input logic [15:0] es, input int lat, input logic ff_live);
        exp_t       e;
        logic [15:0] s;
        logic [8:0]  n;
        logic        b;
        logic        any;
        s   = 16'h0000;
        n   = 9'd0;
        any = 1'b0;
        for (int v = 0; v < 256; v++) begin
            b = po_model(m, 8'(v));
            n = n + {8'h00, b};
            s = sig_step(s, b);
            if (b) any = 1'b1;
        end
        e.tag  = tag;
        e.ones = n;
        e.sig  = s;
        e.pass = (n == eo) && (s == es);
`ifdef NEWTAG_BIST_FIRST_FAIL_EN
        if (ff_live && any) e.pass = 1'b0;
`else
        if (ff_live && any && 1'b0) e.pass = 1'b0;
`endif
        e.lat  = lat;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] model_sig(input int m);
        logic [15:0] s;
        s = 16'h0000;
        for (int v = 0; v < 256; v++) s = sig_step(s, po_model(m, 8'(v)));
        return s;
    endfunction

    // Full sweep on one controller: push expectation, pulse start, wait for
    // done within a bound, then pop and compare.
    task automatic run_sweep(input int which, input string tag, input int m,
                             input logic [8:0] eo, input logic [15:0] es);
        exp_t e;
        int   cyc;
        logic d;
        if (which == 0) begin
            mode = m; exp_ones0 = eo; exp_sig0 = es;
            push_model(tag, m, eo, es, 257, 1'b1);
        end else begin
            exp_ones2 = eo; exp_sig2 = es;
            push_model(tag, 2, eo, es, 259, 1'b0);
        end
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        check({tag, " busy"}, (which == 0) ? busy0 : busy2, 1);
        check({tag, " pass_low"}, (which == 0) ? pass0 : pass2, 0);
        cyc = 0;
        d   = 1'b0;
        while (!d && cyc < 400) begin
            @(negedge clk);
            cyc++;
            d = (which == 0) ? done0 : done2;
        end
        e = sb.pop_front();
        check({e.tag, " latency"}, cyc, e.lat);
        check({e.tag, " ones"}, (which == 0) ? ones0 : ones2, e.ones);
        check({e.tag, " sig"}, (which == 0) ? sig0 : sig2, e.sig);
        check({e.tag, " pass"}, (which == 0) ? pass0 : pass2, e.pass);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
        exp_ones0 = '0; exp_sig0 = '0; exp_ones2 = '0; exp_sig2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst pi_vec", pi0, 0);
        check("rst busy", busy0, 0);
        check("rst done", done0, 0);
        check("rst pass", pass0, 0);
        check("rst ones", ones0, 0);
        check("rst sig", sig0, 16'h0000);
        check("rst busy lat2", busy2, 0);

        run_sweep(0, "zero", 0, 9'd0, 16'h0000);
        run_sweep(0, "and_bad_golden", 1, 9'd2, 16'h0001);
        run_sweep(0, "and_good", 1, 9'd1, model_sig(1));
        run_sweep(0, "pi0_lat0", 2, 9'd128, model_sig(2));
        run_sweep(2, "pi0_lat2", 2, 9'd128, model_sig(2));
        run_sweep(0, "all_ones", 3, 9'h100, model_sig(3));

        // Start while busy is ignored; reset mid-sweep clears everything.
        mode = 3; exp_ones0 = 9'h100; exp_sig0 = model_sig(3);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 50) start0 = 1'b1;
            if (cyc == 51) begin
                start0 = 1'b0;
                check("ignored start pi_vec", pi0, 51);
                check("ignored start ones", ones0, 51);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy0, 0);
        check("midrst pi_vec", pi0, 0);
        check("midrst ones", ones0, 0);
        check("midrst sig", sig0, 16'h0000);
        check("midrst done", done0, 0);
        run_sweep(0, "after_rst", 3, 9'h100, model_sig(3));

`ifdef NEWTAG_BIST_FIRST_FAIL_EN
        run_sweep(0, "first_fail", 4, 9'd1, model_sig(4));
        check("first_fail seen", fail0, 1);
        check("first_fail vec", ffv0, 8'h5A);
        check("first_fail lat2 clean", fail2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
